// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_AW   = 32;
   localparam int DEF_DW   = 32;
   localparam int STARVE_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_F,
      WAIT_D
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE,
      FETCH,
      DATA
   } owner_t;

endpackage

// File: rtl/arb_rsp_reg.sv
// Captures the memory response and replays it as a one-cycle rvalid pulse to
// whichever requester owns the in-flight transaction.
module arb_rsp_reg
   import mem_arb_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          rsp_fire,
   input  owner_t        owner,
   input  logic          is_store,
   input  logic [DW-1:0] mem_rdata,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata
);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         f_rvalid <= 1'b0;
         f_rdata  <= '0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
      end else begin
         f_rvalid <= rsp_fire && (owner == FETCH);
         d_rvalid <= rsp_fire && (owner == DATA);
         if (rsp_fire && (owner == FETCH))
            f_rdata <= mem_rdata;
         // Stores are acknowledged with zero data, whatever the memory returns.
         if (rsp_fire && (owner == DATA))
            d_rdata <= is_store ? '0 : mem_rdata;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and LSU access to one single-port memory, one transaction in flight.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            f_req,
   input  logic [AW-1:0]   f_addr,
   output logic            f_gnt,
   output logic            f_rvalid,
   output logic [DW-1:0]   f_rdata,
   output logic            fetch_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata,
   output logic            err_spurious
);

   arb_state_t state, state_nx;
   owner_t     owner;
   logic       d_store;
   logic       rsp_fire;
   logic       fetch_win;

`ifdef ARB_STARVE_GUARD_EN
   logic [STARVE_W-1:0] starve_cnt;

   always_ff @(posedge CLK) begin
      if (RESET || f_gnt)
         starve_cnt <= '0;
      else if (d_gnt && f_req && (starve_cnt != '1))
         starve_cnt <= starve_cnt + 1'b1;
   end

   assign fetch_win = f_req && d_req && (starve_cnt == STARVE_W'(STARVE_MAX));
`else
   assign fetch_win = 1'b0;
`endif

   assign rsp_fire = mem_rvalid && (state != IDLE);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      f_gnt     = 1'b0;
      d_gnt     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      case (state)
         IDLE: begin
            // A grant during reset would launch a transaction the FSM then forgets.
            if (!RESET) begin
               if (d_req && !fetch_win) begin
                  d_gnt     = 1'b1;
                  mem_req   = 1'b1;
                  mem_we    = d_we;
                  mem_addr  = d_addr;
                  mem_wdata = d_wdata;
                  mem_be    = d_be;
                  state_nx  = WAIT_D;
               end else if (f_req) begin
                  f_gnt    = 1'b1;
                  mem_req  = 1'b1;
                  mem_addr = f_addr;
                  mem_be   = '1;
                  state_nx = WAIT_F;
               end
            end
         end
         WAIT_F, WAIT_D: begin
            if (mem_rvalid)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         owner        <= NONE;
         d_store      <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         state <= state_nx;
         if (d_gnt) begin
            owner   <= DATA;
            d_store <= d_we;
         end else if (f_gnt) begin
            owner <= FETCH;
         end else if (rsp_fire) begin
            owner <= NONE;
         end
         if (mem_rvalid && (state == IDLE))
            err_spurious <= 1'b1;
      end
   end

   arb_rsp_reg #(.DW(DW)) u_rsp_reg (
      .CLK       (CLK),
      .RESET     (RESET),
      .rsp_fire  (rsp_fire),
      .owner     (owner),
      .is_store  (d_store),
      .mem_rdata (mem_rdata),
      .f_rvalid  (f_rvalid),
      .f_rdata   (f_rdata),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata)
   );

   // The instruction word is still being delivered in the rvalid cycle, so IP holds there too.
   assign fetch_stall = (f_req && !f_gnt) || (state == WAIT_F) || f_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory ops and
// responses, monitors pop and compare on mem_req and on each rvalid pulse.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        f_req, f_gnt, f_rvalid, fetch_stall;
   logic [31:0] f_addr, f_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        mem_req, mem_we, mem_rvalid, err_spurious;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_exp_t;

   typedef struct {
      bit          is_fetch;
      logic [31:0] data;
   } rsp_exp_t;

   mem_exp_t    exp_mem[$];
   rsp_exp_t    exp_rsp[$];
   logic [31:0] mem_img[logic [31:0]];
   int          total = 0;
   int          bad = 0;
   int          lat_cfg = 2;

   always #5 CLK = ~CLK;

   mem_port_arbiter dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .f_req        (f_req),
      .f_addr       (f_addr),
      .f_gnt        (f_gnt),
      .f_rvalid     (f_rvalid),
      .f_rdata      (f_rdata),
      .fetch_stall  (fetch_stall),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_be         (d_be),
      .d_gnt        (d_gnt),
      .d_rvalid     (d_rvalid),
      .d_rdata      (d_rdata),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .err_spurious (err_spurious)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic void push_mem(bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
      mem_exp_t m;
      m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
      exp_mem.push_back(m);
   endfunction

   function automatic void push_rsp(bit is_fetch, logic [31:0] data);
      rsp_exp_t r;
      r.is_fetch = is_fetch; r.data = data;
      exp_rsp.push_back(r);
   endfunction

   // Memory model: samples mem_req mid-cycle, answers lat_cfg cycles after the grant.
   initial begin : mem_model
      logic [31:0] rd;
      logic [31:0] word;
      int          lat;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge CLK);
         if (mem_req) begin
            lat = lat_cfg;
            if (mem_we) begin
               word = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'h0;
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
               mem_img[mem_addr] = word;
               rd = 32'hBADC0FFE;
            end else begin
               rd = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'h0;
            end
            repeat (lat) @(posedge CLK);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(posedge CLK);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
         end
      end
   end

   mem_exp_t mon_m;
   always @(negedge CLK) begin
      if (mem_req) begin
         if (exp_mem.size() == 0) begin
            check("mem_req unexpected", mem_req, 1'b0);
         end else begin
            mon_m = exp_mem.pop_front();
            check("mem_we", mem_we, mon_m.we);
            check("mem_addr", mem_addr, mon_m.addr);
            check("mem_be", mem_be, mon_m.be);
            if (mon_m.we) check("mem_wdata", mem_wdata, mon_m.wdata);
         end
      end
   end

   rsp_exp_t mon_r;
   always @(negedge CLK) begin
      if (f_rvalid && d_rvalid) check("both rvalid", {f_rvalid, d_rvalid}, 2'b00);
      if (f_rvalid || d_rvalid) begin
         if (exp_rsp.size() == 0) begin
            check("rvalid unexpected", {f_rvalid, d_rvalid}, 2'b00);
         end else begin
            mon_r = exp_rsp.pop_front();
            check("rsp owner fetch", f_rvalid, mon_r.is_fetch);
            if (mon_r.is_fetch) check("f_rdata", f_rdata, mon_r.data);
            else check("d_rdata", d_rdata, mon_r.data);
         end
      end
   end

   // Single request from one side, bounded wait for its grant.
   task automatic single(input bit fetch, input logic [31:0] addr, input logic [31:0] data, input int lat);
      int n;
      bit got;
      tick();
      lat_cfg = lat;
      push_mem(1'b0, addr, 32'h0, 4'hF);
      push_rsp(fetch, data);
      if (fetch) begin
         f_req = 1'b1; f_addr = addr;
      end else begin
         d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_wdata = '0; d_be = 4'hF;
      end
      got = 1'b0;
      n = 0;
      while (!got && n < 20) begin
         @(negedge CLK);
         got = fetch ? f_gnt : d_gnt;
         if (!got) begin
            tick();
            n++;
         end
      end
      check("single gnt seen", got, 1'b1);
      tick();
      f_req = 1'b0;
      d_req = 1'b0;
      repeat (lat + 4) tick();
   endtask

   initial begin
      int          cyc, ng, d_rv_cyc, f_gnt_cyc;
      logic [9:0]  pat, exp_pat;

      mem_img[32'h40]  = 32'h00000013;
      mem_img[32'h44]  = 32'h00100093;
      mem_img[32'h48]  = 32'h00200113;
      mem_img[32'h100] = 32'hCAFE0001;
      mem_img[32'h200] = 32'h11223344;
      mem_img[32'h300] = 32'h0000BEEF;

      RESET = 1'b1;
      f_req = 1'b0; f_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      repeat (2) tick();
      @(negedge CLK);
      check("reset outputs", {f_gnt, d_gnt, mem_req, f_rvalid, d_rvalid, fetch_stall, err_spurious}, 7'b0);
      check("reset mem_addr", mem_addr, 32'h0);
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      check("idle outputs", {f_gnt, d_gnt, mem_req, f_rvalid, d_rvalid, fetch_stall, err_spurious}, 7'b0);

      // Fetch only, latency 2: grant c0, mem_rvalid c2, f_rvalid c3.
      tick();
      lat_cfg = 2;
      push_mem(1'b0, 32'h40, 32'h0, 4'hF);
      push_rsp(1'b1, 32'h00000013);
      f_req = 1'b1; f_addr = 32'h40;
      @(negedge CLK);
      check("fetch f_gnt c0", f_gnt, 1'b1);
      check("fetch mem_req c0", mem_req, 1'b1);
      check("fetch stall c0", fetch_stall, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 1) f_req = 1'b0;
         @(negedge CLK);
         check("fetch mem_req quiet", mem_req, 1'b0);
         check("fetch stall c1-3", fetch_stall, 1'b1);
         check("fetch f_rvalid timing", f_rvalid, (c == 3));
         if (c == 3) check("fetch f_rdata c3", f_rdata, 32'h13);
      end
      tick();
      @(negedge CLK);
      check("fetch stall released", fetch_stall, 1'b0);

      // Collision: load wins, fetch granted in the d_rvalid cycle.
      tick();
      lat_cfg = 2;
      push_mem(1'b0, 32'h100, 32'h0, 4'hF);
      push_mem(1'b0, 32'h44, 32'h0, 4'hF);
      push_rsp(1'b0, 32'hCAFE0001);
      push_rsp(1'b1, 32'h00100093);
      f_req = 1'b1; f_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = '0; d_be = 4'hF;
      @(negedge CLK);
      check("collision d_gnt", d_gnt, 1'b1);
      check("collision f_gnt held off", f_gnt, 1'b0);
      check("collision stall", fetch_stall, 1'b1);
      tick();
      d_req = 1'b0;
      cyc = 1; d_rv_cyc = -1; f_gnt_cyc = -1;
      while (f_gnt_cyc < 0 && cyc < 30) begin
         @(negedge CLK);
         if (d_rvalid) d_rv_cyc = cyc;
         if (f_gnt) f_gnt_cyc = cyc;
         else begin
            tick();
            cyc++;
         end
      end
      check("collision d_rvalid cycle", d_rv_cyc, 3);
      check("collision f_gnt cycle", f_gnt_cyc, 3);
      tick();
      f_req = 1'b0;
      repeat (6) tick();

      // Store with partial byte enables, latency 1.
      lat_cfg = 1;
      push_mem(1'b1, 32'h200, 32'hDEADBEEF, 4'b0011);
      push_rsp(1'b0, 32'h0);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      @(negedge CLK);
      check("store d_gnt", d_gnt, 1'b1);
      check("store mem_we", mem_we, 1'b1);
      check("store mem_be", mem_be, 4'b0011);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge CLK);
      check("store no fetch stall", fetch_stall, 1'b0);
      repeat (5) tick();
      single(1'b0, 32'h200, 32'h1122BEEF, 2);

      // Reset while in WAIT_D, memory answers two cycles after reset.
      lat_cfg = 3;
      push_mem(1'b0, 32'h100, 32'h0, 4'hF);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
      @(negedge CLK);
      check("rst-txn d_gnt", d_gnt, 1'b1);
      tick();
      d_req = 1'b0;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      check("rst-txn err before late rsp", err_spurious, 1'b0);
      repeat (2) tick();
      @(negedge CLK);
      check("rst-txn err_spurious", err_spurious, 1'b1);
      check("rst-txn no d_rvalid", d_rvalid, 1'b0);
      repeat (3) tick();
      single(1'b1, 32'h48, 32'h00200113, 1);
      check("err_spurious sticky", err_spurious, 1'b1);

      // Both requests held: LSU priority, or 4:1 with the starvation guard.
`ifdef ARB_STARVE_GUARD_EN
      exp_pat = 10'h210;
`else
      exp_pat = 10'h000;
`endif
      lat_cfg = 1;
      for (int i = 0; i < 10; i++) begin
         if (exp_pat[i]) begin
            push_mem(1'b0, 32'h48, 32'h0, 4'hF);
            push_rsp(1'b1, 32'h00200113);
         end else begin
            push_mem(1'b0, 32'h300, 32'h0, 4'hF);
            push_rsp(1'b0, 32'h0000BEEF);
         end
      end
      tick();
      f_req = 1'b1; f_addr = 32'h48;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = '0; d_be = 4'hF;
      ng = 0; cyc = 0; pat = '0;
      while (ng < 10 && cyc < 200) begin
         @(negedge CLK);
         if (d_gnt || f_gnt) begin
            pat[ng] = f_gnt;
            ng++;
         end
         if (ng < 10) begin
            tick();
            cyc++;
         end
      end
      check("starve grant count", ng, 10);
      check("starve grant pattern", pat, exp_pat);
      tick();
      f_req = 1'b0;
      d_req = 1'b0;
      repeat (10) tick();

      check("mem queue drained", exp_mem.size(), 0);
      check("rsp queue drained", exp_rsp.size(), 0);

      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      @(negedge CLK);
      check("err_spurious cleared by reset", err_spurious, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
